// File: rtl/touch_led_mode_controller.sv
// touch_led_mode_controller: synchronizes and debounces a raw touch input,
// classifies short press / double tap / long press gestures and steps a
// three-mode (OFF / ON / BLINK) LED controller from those gestures.
module touch_led_mode_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned DOUBLE_TAP_CYCLES = 15_000_000,
  parameter int unsigned BLINK_HALF_CYCLES = 12_500_000
) (
  input  logic       system_clock,
  input  logic       system_reset_n,
  input  logic       touch_button,
  output logic       led,
  output logic [1:0] led_mode,
  output logic       short_press,
  output logic       double_tap,
  output logic       long_press
);

  localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST  = 32'(LONG_PRESS_CYCLES - 1);
  localparam logic [31:0] DT_LAST    = 32'(DOUBLE_TAP_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    G_IDLE,
    G_PRESSED,
    G_LONG_HELD,
    G_WAIT_SECOND,
    G_SECOND_PRESSED
  } gstate_e;

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2
  } mode_e;

  logic        sync1_q, sync2_q;
  logic        acc_q, acc_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic        pressed_d;

  gstate_e     gst_q;
  logic [31:0] tmr_q;
  logic        short_q, dbl_q, long_q;

  mode_e       mode_q, mode_d;
  logic [31:0] bcnt_q;
  logic        led_q;

  // Two-stage synchronizer; idle level of the pad is 1 (released).
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= touch_button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: accept a new level only after it has differed for the full window.
  always_comb begin
    acc_d  = acc_q;
    dcnt_d = '0;
    if (sync2_q != acc_q) begin
      if (dcnt_q == DEB_LAST) acc_d  = sync2_q;
      else                    dcnt_d = dcnt_q + 32'd1;
    end
  end

  // The gesture FSM looks at the next debounced level so its timing is
  // measured from the very edge at which the debounced level changes.
  assign pressed_d = ~acc_d;

  // Debounce state registers.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      acc_q  <= 1'b1;
      dcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Gesture classifier with registered one-cycle pulses.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      gst_q   <= G_IDLE;
      tmr_q   <= '0;
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      case (gst_q)
        G_IDLE: begin
          if (pressed_d) begin
            gst_q <= G_PRESSED;
            tmr_q <= '0;
          end
        end
        G_PRESSED: begin
          // Release wins over the long-press threshold on the same cycle.
          if (!pressed_d) begin
            gst_q <= G_WAIT_SECOND;
            tmr_q <= '0;
          end else if (tmr_q == LONG_LAST) begin
            long_q <= 1'b1;
            gst_q  <= G_LONG_HELD;
          end else begin
            tmr_q <= tmr_q + 32'd1;
          end
        end
        G_LONG_HELD: begin
          if (!pressed_d) gst_q <= G_IDLE;
        end
        G_WAIT_SECOND: begin
          if (pressed_d) begin
            gst_q <= G_SECOND_PRESSED;
          end else if (tmr_q == DT_LAST) begin
            short_q <= 1'b1;
            gst_q   <= G_IDLE;
          end else begin
            tmr_q <= tmr_q + 32'd1;
          end
        end
        G_SECOND_PRESSED: begin
          if (!pressed_d) begin
            dbl_q <= 1'b1;
            gst_q <= G_IDLE;
          end
        end
        default: gst_q <= G_IDLE;
      endcase
    end
  end

  // Mode transitions driven by the gesture pulses (never more than one at a time).
  always_comb begin
    mode_d = mode_q;
    if (long_q)       mode_d = M_OFF;
    else if (short_q) mode_d = (mode_q == M_OFF) ? M_ON : M_OFF;
    else if (dbl_q)   mode_d = (mode_q == M_BLINK) ? M_ON : M_BLINK;
  end

  // Mode register, blink timer and LED drive, all updated together.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      mode_q <= M_OFF;
      bcnt_q <= '0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      if (mode_d == M_BLINK) begin
        if (mode_q != M_BLINK) begin
          bcnt_q <= '0;
          led_q  <= 1'b1;
        end else if (bcnt_q == BLINK_LAST) begin
          bcnt_q <= '0;
          led_q  <= ~led_q;
        end else begin
          bcnt_q <= bcnt_q + 32'd1;
        end
      end else begin
        bcnt_q <= '0;
        led_q  <= (mode_d == M_ON);
      end
    end
  end

  assign led         = led_q;
  assign led_mode    = mode_q;
  assign short_press = short_q;
  assign double_tap  = dbl_q;
  assign long_press  = long_q;

endmodule

// File: doc/touch_led_mode_controller.md
# touch_led_mode_controller

Gesture controller sequencing the touch-button/LED datapath. It synchronizes and debounces the raw `touch_button` input, then classifies each gesture as short press, double tap or long press. Each gesture steps a three-mode LED state machine: OFF, ON or BLINK. It sits between the touch sensor pin and the board LED, in place of the direct button-to-LED path.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50_000 — consecutive stable cycles required to accept a level change (1 ms @ 50 MHz).
- `LONG_PRESS_CYCLES`, 50_000_000 — held-press duration that counts as a long press (1 s).
- `DOUBLE_TAP_CYCLES`, 15_000_000 — window after a release in which a second press counts as a double tap (300 ms).
- `BLINK_HALF_CYCLES`, 12_500_000 — LED half-period in BLINK mode (250 ms).

All parameters must be ≥ 2; the internal counters are 32 bits wide.

Ports:
- `system_clock` input 1 — single clock, 50 MHz nominal.
- `system_reset_n` input 1 — asynchronous, active-low reset.
- `touch_button` input 1 — raw asynchronous input; 1 = released, 0 = touched.
- `led` output 1 — LED drive, 1 = lit.
- `led_mode` output 2 — 2'd0 OFF, 2'd1 ON, 2'd2 BLINK; 2'd3 is never driven.
- `short_press` output 1 — one-cycle pulse when a short press is classified.
- `double_tap` output 1 — one-cycle pulse when a double tap is classified.
- `long_press` output 1 — one-cycle pulse when a long press is classified.

## Operation
- **Synchronizer:** two flip-flops on `touch_button`, both reset to 1.
- **Debounce:**
  - The debounced level `pressed` is the inverted accepted level; it resets to 0.
  - A counter increments while the synchronized level differs from the accepted level.
  - The counter clears whenever the two levels match.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the accepted level updates.
  - Glitches shorter than `DEBOUNCE_CYCLES` are therefore ignored.
- **Gesture FSM** (states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; one 32-bit timer):
  - IDLE: `pressed` rises → PRESSED, timer = 0.
  - PRESSED: timer counts up.
    - Timer reaches `LONG_PRESS_CYCLES-1` while still pressed → pulse `long_press`, go to LONG_HELD.
    - Release before that → WAIT_SECOND, timer = 0.
  - LONG_HELD: release → IDLE. No further pulses, however long the hold.
  - WAIT_SECOND: timer counts up.
    - Press → SECOND_PRESSED.
    - Timer reaches `DOUBLE_TAP_CYCLES-1` with no press → pulse `short_press`, go to IDLE.
  - SECOND_PRESSED: release → pulse `double_tap`, go to IDLE. Hold length is irrelevant here.
- **Mode FSM** (`led_mode`):
  - `short_press`: OFF→ON, ON→OFF, BLINK→OFF.
  - `double_tap`: OFF→BLINK, ON→BLINK, BLINK→ON.
  - `long_press`: any mode → OFF.
  - At most one gesture pulse is asserted per cycle, so there are no simultaneous events.
- **LED output:**
  - OFF → 0; ON → 1.
  - On entry to BLINK, the blink counter clears and `led` = 1.
  - In BLINK, `led` toggles every `BLINK_HALF_CYCLES` cycles.
  - Leaving BLINK clears the blink counter.

## Timing
- **Reset values:** `led`=0, `led_mode`=0, all pulses 0, FSMs in IDLE/OFF, counters 0.
- **Reset mid-gesture:** any in-progress gesture is discarded and no pulse is emitted.
- **Press latency:** 2 synchronizer cycles + `DEBOUNCE_CYCLES` from the raw 1→0 edge to `pressed`=1. Release latency is identical.
- **Classification timing:**
  - `long_press` asserts exactly `LONG_PRESS_CYCLES` cycles after `pressed` rises.
  - `short_press` asserts `DOUBLE_TAP_CYCLES` cycles after `pressed` falls.
  - `double_tap` asserts the cycle after `pressed` falls in SECOND_PRESSED.
- **Mode update:** `led_mode` and `led` update on the cycle after the gesture pulse.
- **Pulses:** all registered, exactly one cycle wide.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=50, `DOUBLE_TAP_CYCLES`=20, `BLINK_HALF_CYCLES`=8; 20 ns clock.
1. **Reset:** hold `system_reset_n`=0 for 20 ns, button=1 → `led`=0, `led_mode`=0, no pulses; after release, idle 100 cycles → outputs unchanged.
2. **Glitch rejection:** button=0 for 3 cycles, then 1 → no pulses, `led_mode` stays 0.
3. **Short press:** button=0 for 20 cycles, then 1 → one `short_press` pulse, `led_mode`=1, `led`=1; repeat → `led_mode`=0, `led`=0.
4. **Double tap:** two 10-cycle presses 10 cycles apart → one `double_tap`, no `short_press`, `led_mode`=2; `led` high 8 cycles, low 8, repeating; another double tap → `led_mode`=1, `led`=1.
5. **Long press:** from BLINK, hold 0 for 200 cycles → single `long_press` 50 cycles after debounced press, `led_mode`=0, no pulse on release.
6. **Reset mid-gesture:** assert reset during WAIT_SECOND → no `short_press`, all outputs at reset values.
